operand_sequencer: RTL and testbench

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer.sv | 141 ++++++++++++++
 tb/tb_operand_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// Two-player operand entry followed by a WIDTH-cycle shift-and-add multiply.
// Enter strobes are edge-detected; res updates only when a full product is ready.
module operand_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             enter1,
  input  logic             enter2,
  output logic [7:0]       res,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stage
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [7:0]       acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             e1_q, e1_d;
  logic             e2_q, e2_d;
  logic [7:0]       res_q, res_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             press1;
  logic             press2;
  logic [7:0]       a_ext;
  logic [7:0]       addend;
  logic [7:0]       sum;

  // Next-state, operand latching and one multiply step per S_MUL cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    done_d  = 1'b0;
    e1_d    = enter1;
    e2_d    = enter2;
    press1  = enter1 & ~e1_q;
    press2  = enter2 & ~e2_q;
    a_ext   = {{(8-WIDTH){1'b0}}, a_q};
    if (b_q[cnt_q]) begin
      addend = a_ext << cnt_q;
    end else begin
      addend = 8'd0;
    end
    sum = acc_q + addend;

    case (state_q)
      S_A, S_DONE: begin
        if (press1) begin
          a_d     = num1;
          state_d = S_B;
        end else begin
          state_d = state_q;
        end
      end
      S_B: begin
        if (press1) begin
          a_d = num1;
        end else begin
          a_d = a_q;
        end
        if (press2) begin
          b_d     = num2;
          acc_d   = 8'd0;
          cnt_d   = {CW{1'b0}};
          state_d = S_MUL;
        end else begin
          state_d = S_B;
        end
      end
      S_MUL: begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          res_d   = sum;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase

    busy_d = (state_d == S_MUL);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_A;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= 8'd0;
      cnt_q   <= {CW{1'b0}};
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
      res_q   <= 8'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign res   = res_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign stage = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer (WIDTH=3): each task drives one scenario
// and compares against hand-computed products and stage codes.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] num1 = 3'd0;
  logic [2:0] num2 = 3'd0;
  logic       enter1 = 1'b0;
  logic       enter2 = 1'b0;
  logic [7:0] res;
  logic       busy;
  logic       done;
  logic [1:0] stage;

  int total = 0;
  int bad = 0;

  operand_sequencer #(.WIDTH(3)) dut (
    .clk(clk), .reset(reset), .num1(num1), .num2(num2),
    .enter1(enter1), .enter2(enter2),
    .res(res), .busy(busy), .done(done), .stage(stage)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press1(input logic [2:0] v);
    num1 = v; enter1 = 1'b1; tick();
    enter1 = 1'b0; tick();
  endtask

  // leaves the bench one sample after the edge that took the enter2 press
  task automatic press2(input logic [2:0] v);
    num2 = v; enter2 = 1'b1; tick();
    enter2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enter1 = 1'b0; enter2 = 1'b0;
    tick(); tick();
    total++; if ({stage, busy, done} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got %b exp 0000", {stage, busy, done}); end
    total++; if (res !== 8'h00) begin bad++; $display("FAIL reset_res got %h exp 00", res); end
    reset = 1'b1; tick();
  endtask

  task automatic test_basic();
    press1(3'd1);
    total++; if (stage !== 2'b01) begin bad++; $display("FAIL basic_sb got %b exp 01", stage); end
    press2(3'd1);
    for (int i = 0; i < 3; i++) begin
      total++; if ({stage, busy, done} !== 4'b1010) begin bad++; $display("FAIL basic_mul%0d got %b exp 1010", i, {stage, busy, done}); end
      total++; if (res !== 8'h00) begin bad++; $display("FAIL basic_early_res%0d got %h exp 00", i, res); end
      tick();
    end
    total++; if ({stage, busy, done} !== 4'b1101) begin bad++; $display("FAIL basic_done got %b exp 1101", {stage, busy, done}); end
    total++; if (res !== 8'h01) begin bad++; $display("FAIL basic_res got %h exp 01", res); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_max();
    int busy_cycles = 0;
    press1(3'd7);
    press2(3'd7);
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cycles++;
      tick();
    end
    total++; if (busy_cycles !== 3) begin bad++; $display("FAIL max_busy got %0d exp 3", busy_cycles); end
    total++; if (res !== 8'h31) begin bad++; $display("FAIL max_res got %h exp 31", res); end
    total++; if (stage !== 2'b11) begin bad++; $display("FAIL max_stage got %b exp 11", stage); end
  endtask

  task automatic test_zero();
    press1(3'd5);
    press2(3'd0);
    tick(); tick(); tick();
    total++; if ({done, res} !== 9'h100) begin bad++; $display("FAIL zero_res got %h exp 100", {done, res}); end
    press1(3'd3);
    press2(3'd2);
    tick(); tick(); tick();
    total++; if ({done, res} !== 9'h106) begin bad++; $display("FAIL zero_next_res got %h exp 106", {done, res}); end
  endtask

  task automatic test_ignore_and_hold();
    reset = 1'b0; tick(); reset = 1'b1;
    press2(3'd4); tick();
    total++; if (stage !== 2'b00) begin bad++; $display("FAIL sa_enter2 got %b exp 00", stage); end
    num1 = 3'd2; enter1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      num1 = 3'd5;
      total++; if (stage !== 2'b01) begin bad++; $display("FAIL hold_stage%0d got %b exp 01", i, stage); end
    end
    enter1 = 1'b0; tick();
    total++; if (res !== 8'h00) begin bad++; $display("FAIL hold_res got %h exp 00", res); end
    press2(3'd3);
    tick(); tick(); tick();
    total++; if (res !== 8'h06) begin bad++; $display("FAIL hold_one_press got %h exp 06", res); end
  endtask

  task automatic test_overwrite();
    press1(3'd2);
    press1(3'd6);
    total++; if (stage !== 2'b01) begin bad++; $display("FAIL ovw_stage got %b exp 01", stage); end
    press2(3'd3);
    tick(); tick(); tick();
    total++; if (res !== 8'h12) begin bad++; $display("FAIL ovw_res got %h exp 12", res); end
  endtask

  task automatic test_simultaneous();
    press1(3'd4);
    num1 = 3'd5; num2 = 3'd3; enter1 = 1'b1; enter2 = 1'b1; tick();
    enter1 = 1'b0; enter2 = 1'b0;
    total++; if (stage !== 2'b10) begin bad++; $display("FAIL simul_stage got %b exp 10", stage); end
    tick(); tick(); tick();
    total++; if (res !== 8'h0f) begin bad++; $display("FAIL simul_res got %h exp 0f", res); end
  endtask

  task automatic test_ignore_in_mul();
    press1(3'd6);
    press2(3'd2);
    num1 = 3'd1; num2 = 3'd1; enter1 = 1'b1; enter2 = 1'b1; tick();
    enter1 = 1'b0; enter2 = 1'b0; tick(); tick();
    total++; if ({stage, res} !== 10'h30c) begin bad++; $display("FAIL mul_ignore got %h exp 30c", {stage, res}); end
    tick();
    total++; if (stage !== 2'b11) begin bad++; $display("FAIL mul_no_queue got %b exp 11", stage); end
  endtask

  task automatic test_reset_mid_mul();
    int done_seen = 0;
    press1(3'd7);
    press2(3'd7);
    tick();
    reset = 1'b0;
    if (done) done_seen++;
    tick();
    total++; if ({stage, busy, done} !== 4'b0000) begin bad++; $display("FAIL mid_rst_ctrl got %b exp 0000", {stage, busy, done}); end
    total++; if (res !== 8'h00) begin bad++; $display("FAIL mid_rst_res got %h exp 00", res); end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (done) done_seen++;
      tick();
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL mid_rst_done got %0d exp 0", done_seen); end
    total++; if (res !== 8'h00) begin bad++; $display("FAIL mid_rst_res_hold got %h exp 00", res); end
  endtask

  task automatic test_strobe_at_release();
    reset = 1'b0; num1 = 3'd3; enter1 = 1'b1; tick();
    reset = 1'b1; tick();
    total++; if (stage !== 2'b01) begin bad++; $display("FAIL release_press got %b exp 01", stage); end
    enter1 = 1'b0; tick();
    press2(3'd2);
    tick(); tick(); tick();
    total++; if (res !== 8'h06) begin bad++; $display("FAIL release_res got %h exp 06", res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_and_hold();
    test_overwrite();
    test_simultaneous();
    test_ignore_in_mul();
    test_reset_mid_mul();
    test_strobe_at_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
